// File: rtl/line_gen_stream.sv
// Streaming 8-octant Bresenham line generator with ready/valid pixel output.
// Optional clip window enabled by defining LINE_GEN_CLIP_EN.
module line_gen_stream #(
  parameter int CW   = 12,
  parameter int CNTW = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 start_rdy,
  input  logic                 abort,
  input  logic signed [CW-1:0] aX,
  input  logic signed [CW-1:0] aY,
  input  logic signed [CW-1:0] bX,
  input  logic signed [CW-1:0] bY,
`ifdef LINE_GEN_CLIP_EN
  input  logic signed [CW-1:0] clip_x0,
  input  logic signed [CW-1:0] clip_y0,
  input  logic signed [CW-1:0] clip_x1,
  input  logic signed [CW-1:0] clip_y1,
`endif
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic signed [CW-1:0] pix_x,
  output logic signed [CW-1:0] pix_y,
  output logic                 pix_last,
  output logic                 busy,
  output logic                 line_done,
  output logic [CNTW-1:0]      pix_count
);

  localparam int EW = CW + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state;
  logic signed [CW-1:0] ax_q, ay_q, bx_q, by_q;
  logic signed [CW-1:0] x_q, y_q, sx_q, sy_q;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic [CNTW-1:0]      cnt_q;

  logic signed [EW-1:0] ddx, ddy, adx, ady;
  logic signed [EW:0]   e2, dx_w, dy_w;
  logic signed [EW-1:0] err_n;
  logic signed [CW-1:0] x_n, y_n;
  logic                 at_end, vis, in_draw, hs, adv;

  assign ddx = EW'(bx_q) - EW'(ax_q);
  assign ddy = EW'(by_q) - EW'(ay_q);
  assign adx = ddx[EW-1] ? -ddx : ddx;
  assign ady = ddy[EW-1] ? -ddy : ddy;

  assign e2   = $signed({err_q, 1'b0});
  assign dx_w = (EW+1)'(dx_q);
  assign dy_w = (EW+1)'(dy_q);

  always_comb begin
    err_n = err_q;
    x_n   = x_q;
    y_n   = y_q;
    if (e2 >= dy_w) begin
      err_n = err_n + dy_q;
      x_n   = x_q + sx_q;
    end
    if (e2 <= dx_w) begin
      err_n = err_n + dx_q;
      y_n   = y_q + sy_q;
    end
  end

`ifdef LINE_GEN_CLIP_EN
  logic signed [CW-1:0] cx0_q, cy0_q, cx1_q, cy1_q;

  assign vis = (x_q >= cx0_q) && (x_q <= cx1_q) &&
               (y_q >= cy0_q) && (y_q <= cy1_q);
`else
  assign vis = 1'b1;
`endif

  assign at_end  = (x_q == bx_q) && (y_q == by_q);
  assign in_draw = (state == S_DRAW);
  assign hs      = pix_valid && pix_ready;
  // hidden points advance on their own, one per cycle
  assign adv     = in_draw && (hs || !vis);

  assign start_rdy = (state == S_IDLE);
  assign busy      = (state == S_SETUP) || in_draw;
  assign line_done = (state == S_DONE);
  assign pix_valid = in_draw && vis;
  assign pix_last  = pix_valid && at_end;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ax_q  <= '0;
      ay_q  <= '0;
      bx_q  <= '0;
      by_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      err_q <= '0;
      cnt_q <= '0;
`ifdef LINE_GEN_CLIP_EN
      cx0_q <= '0;
      cy0_q <= '0;
      cx1_q <= '0;
      cy1_q <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ax_q  <= aX;
            ay_q  <= aY;
            bx_q  <= bX;
            by_q  <= bY;
            cnt_q <= '0;
`ifdef LINE_GEN_CLIP_EN
            cx0_q <= clip_x0;
            cy0_q <= clip_y0;
            cx1_q <= clip_x1;
            cy1_q <= clip_y1;
`endif
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            dx_q  <= adx;
            dy_q  <= -ady;
            err_q <= adx - ady;
            sx_q  <= (ddx == '0) ? '0 : (ddx[EW-1] ? '1 : CW'(1));
            sy_q  <= (ddy == '0) ? '0 : (ddy[EW-1] ? '1 : CW'(1));
            x_q   <= ax_q;
            y_q   <= ay_q;
            state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (hs) cnt_q <= cnt_q + CNTW'(1);
          if (abort) begin
            state <= S_IDLE;
          end else if (adv) begin
            if (at_end) begin
              state <= S_DONE;
            end else begin
              x_q   <= x_n;
              y_q   <= y_n;
              err_q <= err_n;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_gen_stream.sv
// Directed self-checking bench for line_gen_stream.
// Clip cases are built when LINE_GEN_CLIP_EN is defined.
module tb_line_gen_stream;

  localparam int CW   = 12;
  localparam int CNTW = 13;

  logic                 clk = 1'b0;
  logic                 reset, start, abort, pix_ready;
  logic signed [CW-1:0] aX, aY, bX, bY;
  logic                 start_rdy, pix_valid, pix_last, busy, line_done;
  logic signed [CW-1:0] pix_x, pix_y;
  logic [CNTW-1:0]      pix_count;
`ifdef LINE_GEN_CLIP_EN
  logic signed [CW-1:0] clip_x0, clip_y0, clip_x1, clip_y1;
`endif

  line_gen_stream #(.CW(CW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_rdy (start_rdy),
    .abort     (abort),
    .aX        (aX),
    .aY        (aY),
    .bX        (bX),
    .bY        (bY),
`ifdef LINE_GEN_CLIP_EN
    .clip_x0   (clip_x0),
    .clip_y0   (clip_y0),
    .clip_x1   (clip_x1),
    .clip_y1   (clip_y1),
`endif
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .busy      (busy),
    .line_done (line_done),
    .pix_count (pix_count)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  int got_x[$], got_y[$], got_l[$];
  int ex[$], ey[$];
  bit done_seen;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int ax, input int ay,
                            input int bx, input int by);
    aX    = CW'(ax);
    aY    = CW'(ay);
    bX    = CW'(bx);
    bY    = CW'(by);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // pat 0: always ready; pat 1: ready on every third cycle
  task automatic collect(input int pat);
    int  hx, hy;
    bit  held;
    got_x.delete();
    got_y.delete();
    got_l.delete();
    done_seen = 1'b0;
    held      = 1'b0;
    hx        = 0;
    hy        = 0;
    for (int c = 0; c < 200; c++) begin
      if (line_done) begin
        done_seen = 1'b1;
        break;
      end
      if (held) begin
        check("stall_valid", int'(pix_valid), 1);
        check("stall_x", int'(pix_x), hx);
        check("stall_y", int'(pix_y), hy);
      end
      pix_ready = (pat == 0) ? 1'b1 : (c % 3 == 0);
      held = 1'b0;
      if (pix_valid) begin
        if (pix_ready) begin
          got_x.push_back(int'(pix_x));
          got_y.push_back(int'(pix_y));
          got_l.push_back(int'(pix_last));
        end else begin
          held = 1'b1;
          hx   = int'(pix_x);
          hy   = int'(pix_y);
        end
      end
      tick();
    end
    check("line_done_seen", int'(done_seen), 1);
    pix_ready = 1'b0;
  endtask

  task automatic expect_pts(input string tag, input bit last_exp);
    int n;
    n = ex.size();
    check({tag, "_npix"}, got_x.size(), n);
    for (int i = 0; i < n && i < got_x.size(); i++) begin
      check({tag, "_x"}, got_x[i], ex[i]);
      check({tag, "_y"}, got_y[i], ey[i]);
      check({tag, "_last"}, got_l[i], (i == n - 1) ? int'(last_exp) : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_rdy"}, int'(start_rdy), 1);
    check({tag, "_pix_valid"}, int'(pix_valid), 0);
    check({tag, "_pix_x"}, int'(pix_x), 0);
    check({tag, "_pix_y"}, int'(pix_y), 0);
    check({tag, "_pix_last"}, int'(pix_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_line_done"}, int'(line_done), 0);
    check({tag, "_pix_count"}, int'(pix_count), 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    pix_ready = 1'b0;
    aX = '0; aY = '0; bX = '0; bY = '0;
`ifdef LINE_GEN_CLIP_EN
    clip_x0 = -CW'(2048);
    clip_y0 = -CW'(2048);
    clip_x1 = CW'(2047);
    clip_y1 = CW'(2047);
`endif
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // single point: first pixel two edges after accept
    start_line(5, 5, 5, 5);
    pix_ready = 1'b1;
    check("sp_busy", int'(busy), 1);
    check("sp_setup_valid", int'(pix_valid), 0);
    check("sp_start_rdy", int'(start_rdy), 0);
    tick();
    check("sp_valid", int'(pix_valid), 1);
    check("sp_x", int'(pix_x), 5);
    check("sp_y", int'(pix_y), 5);
    check("sp_last", int'(pix_last), 1);
    check("sp_done_early", int'(line_done), 0);
    tick();
    check("sp_done", int'(line_done), 1);
    check("sp_valid_off", int'(pix_valid), 0);
    check("sp_busy_off", int'(busy), 0);
    check("sp_count", int'(pix_count), 1);
    pix_ready = 1'b0;
    tick();
    check("sp_done_pulse", int'(line_done), 0);
    check("sp_idle", int'(start_rdy), 1);
    check("sp_count_hold", int'(pix_count), 1);

    // horizontal
    start_line(0, 0, 7, 0);
    collect(0);
    ex = '{0, 1, 2, 3, 4, 5, 6, 7};
    ey = '{0, 0, 0, 0, 0, 0, 0, 0};
    expect_pts("hor", 1'b1);
    check("hor_count", int'(pix_count), 8);
    tick();

    // steep negative, with a stray start held during the line
    start_line(3, 10, 0, 0);
    start = 1'b1;
    aX = CW'(9); aY = CW'(9); bX = CW'(1); bY = CW'(2);
    collect(0);
    start = 1'b0;
    ex = '{3, 3, 2, 2, 2, 1, 1, 1, 1, 0, 0};
    ey = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    expect_pts("steep", 1'b1);
    check("steep_count", int'(pix_count), 11);
    tick();

    // backpressure
    start_line(0, 0, 4, 2);
    collect(1);
    ex = '{0, 1, 2, 3, 4};
    ey = '{0, 1, 1, 2, 2};
    expect_pts("bp", 1'b1);
    check("bp_count", int'(pix_count), 5);
    tick();

    // abort after three handshakes, while stalled
    start_line(0, 0, 20, 0);
    pix_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    pix_ready = 1'b0;
    check("ab_x_before", int'(pix_x), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", int'(pix_valid), 0);
    check("ab_busy", int'(busy), 0);
    check("ab_done", int'(line_done), 0);
    check("ab_count", int'(pix_count), 3);
    check("ab_idle", int'(start_rdy), 1);
    tick();
    check("ab_done_later", int'(line_done), 0);

    // abort coinciding with a handshake still counts the pixel
    start_line(0, 0, 20, 0);
    pix_ready = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort     = 1'b0;
    pix_ready = 1'b0;
    check("abhs_count", int'(pix_count), 1);
    check("abhs_valid", int'(pix_valid), 0);
    check("abhs_done", int'(line_done), 0);
    tick();

    // reset mid-line, together with abort
    start_line(0, 0, 20, 0);
    pix_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("rml_busy", int'(busy), 1);
    reset = 1'b1;
    abort = 1'b1;
    tick();
    reset     = 1'b0;
    abort     = 1'b0;
    pix_ready = 1'b0;
    check_reset_outputs("rml");

`ifdef LINE_GEN_CLIP_EN
    clip_x0 = CW'(2);
    clip_y0 = CW'(0);
    clip_x1 = CW'(5);
    clip_y1 = CW'(0);
    start_line(0, 0, 7, 0);
    collect(0);
    ex = '{2, 3, 4, 5};
    ey = '{0, 0, 0, 0};
    expect_pts("clip", 1'b0);
    check("clip_count", int'(pix_count), 4);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
